// File: rtl/logic_cell_cluster.sv
// rtl/logic_cell_cluster.sv - cluster of LUT logic cells with carry chain and serial LUT reload
module logic_cell_cluster #(
    parameter int NUM_CELLS = 8,
    parameter int LUT_K     = 4,
    parameter logic [NUM_CELLS*(2**LUT_K)-1:0] LUT_INIT = '0,
    parameter logic [NUM_CELLS-1:0] REG_MASK = '1,
    parameter logic [NUM_CELLS-1:0] C_ON     = '0
) (
    input  logic                         i_clk,
    input  logic                         i_sr,
    input  logic                         i_ce,
    input  logic                         i_carryin,
    input  logic [NUM_CELLS*LUT_K-1:0]   i_in,
    output logic [NUM_CELLS-1:0]         o_lcout,
    output logic                         o_carryout,
    input  logic                         i_cfg_start,
    input  logic                         i_cfg_valid,
    input  logic                         i_cfg_data,
    output logic                         o_cfg_ready,
    output logic                         o_cfg_done
);
    localparam int D     = 1 << LUT_K;
    localparam int CELLW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int CW    = LUT_K + CELLW;
    localparam logic [CW-1:0] LAST = CW'(NUM_CELLS*D - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {ST_RUN, ST_LOAD} state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CW-1:0]                 r_cnt;
    logic [CW-1:0]                 w_cnt_nxt;
    logic                          r_done;
    logic                          w_done_nxt;
    logic                          w_wr_en;
    logic [NUM_CELLS-1:0][D-1:0]   r_lut;
    logic [NUM_CELLS-1:0]          r_q;
    logic [NUM_CELLS-1:0]          w_lut_out;
    logic [NUM_CELLS-1:0]          w_cell;
    logic                          w_carry;

    always_ff @(posedge i_clk) begin
        if (i_sr) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // A restart inside LOAD only rewinds the counter; already-written bits are kept.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_wr_en     = 1'b0;
        o_cfg_ready = (r_state == ST_LOAD);
        o_cfg_done  = r_done;
        case (r_state)
            ST_RUN: begin
                if (i_cfg_start) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (i_cfg_start) begin
                    w_cnt_nxt = '0;
                end else if (i_cfg_valid) begin
                    w_wr_en = 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_sr) begin
            r_lut <= LUT_INIT;
            r_q   <= '0;
        end else begin
            if (w_wr_en) begin
                r_lut[r_cnt[CW-1:LUT_K]][r_cnt[LUT_K-1:0]] <= i_cfg_data;
            end
            if (r_state == ST_LOAD) begin
                r_q <= '0;
            end else if (i_ce) begin
                r_q <= w_lut_out;
            end
        end
    end

    always_comb begin
        w_lut_out = '0;
        w_cell    = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            w_lut_out[i] = r_lut[i][i_in[i*LUT_K +: LUT_K]];
            w_cell[i]    = REG_MASK[i] ? r_q[i] : w_lut_out[i];
        end
    end

    // Ripple carry: a = local input 1, b = local input 2 of each cell.
    always_comb begin
        w_carry = i_carryin;
        for (int i = 0; i < NUM_CELLS; i++) begin
            w_carry = C_ON[i] ? ((i_in[i*LUT_K+1] & i_in[i*LUT_K+2]) |
                                 ((i_in[i*LUT_K+1] | i_in[i*LUT_K+2]) & w_carry))
                              : 1'b0;
        end
    end

    assign o_lcout    = (r_state == ST_LOAD) ? '0 : w_cell;
    assign o_carryout = (r_state == ST_LOAD) ? 1'b0 : w_carry;

endmodule

// File: tb/tb_logic_cell_cluster.sv
// tb/tb_logic_cell_cluster.sv - directed self-checking bench for logic_cell_cluster
module tb_logic_cell_cluster;
    logic       clk = 1'b0;
    logic       sr = 1'b1;
    logic       ce = 1'b0;
    logic       carryin = 1'b0;
    logic [7:0] in_v = 8'h00;
    logic [1:0] lcout;
    logic       carryout;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_data = 1'b0;
    logic       cfg_ready;
    logic       cfg_done;

    int total = 0;
    int bad = 0;

    logic_cell_cluster #(
        .NUM_CELLS(2),
        .LUT_K(4),
        .LUT_INIT(32'hFFFE_8000),
        .REG_MASK(2'b01),
        .C_ON(2'b11)
    ) dut (
        .i_clk(clk),
        .i_sr(sr),
        .i_ce(ce),
        .i_carryin(carryin),
        .i_in(in_v),
        .o_lcout(lcout),
        .o_carryout(carryout),
        .i_cfg_start(cfg_start),
        .i_cfg_valid(cfg_valid),
        .i_cfg_data(cfg_data),
        .o_cfg_ready(cfg_ready),
        .o_cfg_done(cfg_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sr = 1'b1; cfg_start = 1'b1; ce = 1'b1; in_v = 8'h00; carryin = 1'b0;
        tick();
        tick();
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", cfg_ready); end
        total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", cfg_done); end
        total++; if (lcout !== 2'b00) begin bad++; $display("FAIL reset_lcout got=%b exp=00", lcout); end
        total++; if (carryout !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carryout); end
        in_v = 8'h10;
        #1;
        total++; if (lcout !== 2'b10) begin bad++; $display("FAIL reset_comb got=%b exp=10", lcout); end
        sr = 1'b0; cfg_start = 1'b0; in_v = 8'h00;
        tick();
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL after_reset_ready got=%b exp=0", cfg_ready); end
    endtask

    task automatic test_registered();
        in_v = 8'h0F; ce = 1'b1;
        #1;
        total++; if (lcout !== 2'b00) begin bad++; $display("FAIL reg_before_edge got=%b exp=00", lcout); end
        tick();
        total++; if (lcout !== 2'b01) begin bad++; $display("FAIL reg_capture got=%b exp=01", lcout); end
        ce = 1'b0; in_v = 8'h00;
        tick();
        tick();
        total++; if (lcout !== 2'b01) begin bad++; $display("FAIL reg_hold got=%b exp=01", lcout); end
        ce = 1'b1;
        tick();
        total++; if (lcout !== 2'b00) begin bad++; $display("FAIL reg_recapture got=%b exp=00", lcout); end
    endtask

    task automatic test_carry();
        in_v = 8'h22; carryin = 1'b1;
        #1;
        total++; if (carryout !== 1'b1) begin bad++; $display("FAIL carry_prop1 got=%b exp=1", carryout); end
        carryin = 1'b0;
        #1;
        total++; if (carryout !== 1'b0) begin bad++; $display("FAIL carry_prop0 got=%b exp=0", carryout); end
        in_v = 8'h66;
        #1;
        total++; if (carryout !== 1'b1) begin bad++; $display("FAIL carry_gen got=%b exp=1", carryout); end
        in_v = 8'h02; carryin = 1'b1;
        #1;
        total++; if (carryout !== 1'b0) begin bad++; $display("FAIL carry_kill got=%b exp=0", carryout); end
    endtask

    task automatic test_load_toggle();
        int accepted = 0;
        int cyc = 0;
        int err_ready = 0;
        int err_done = 0;
        in_v = 8'h66; carryin = 1'b1; ce = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b exp=1", cfg_ready); end
        total++; if ({lcout, carryout} !== 3'b000) begin bad++; $display("FAIL load_outputs got=%b exp=000", {lcout, carryout}); end
        in_v = 8'h00;
        while (accepted < 32 && cyc < 200) begin
            cfg_valid = (cyc % 2 == 0);
            cfg_data = 1'b1;
            if (cfg_ready !== 1'b1) err_ready++;
            @(posedge clk);
            if (cfg_valid) accepted++;
            #1;
            if (accepted < 32 && cfg_done !== 1'b0) err_done++;
            cyc++;
        end
        cfg_valid = 1'b0;
        total++; if (err_ready != 0) begin bad++; $display("FAIL toggle_ready_low got=%0d exp=0", err_ready); end
        total++; if (err_done != 0) begin bad++; $display("FAIL toggle_early_done got=%0d exp=0", err_done); end
        total++; if (cfg_done !== 1'b1) begin bad++; $display("FAIL toggle_done got=%b exp=1", cfg_done); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL toggle_ready_after got=%b exp=0", cfg_ready); end
        total++; if (lcout !== 2'b10) begin bad++; $display("FAIL first_run_cycle got=%b exp=10", lcout); end
        tick();
        total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", cfg_done); end
        total++; if (lcout !== 2'b11) begin bad++; $display("FAIL all_ones got=%b exp=11", lcout); end
    endtask

    task automatic test_abort();
        int err_done = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            cfg_valid = 1'b1; cfg_data = 1'b0;
            tick();
            if (cfg_done !== 1'b0) err_done++;
        end
        sr = 1'b1;
        tick();
        sr = 1'b0; cfg_valid = 1'b0; in_v = 8'h00;
        #1;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", cfg_ready); end
        total++; if (lcout !== 2'b00) begin bad++; $display("FAIL abort_comb_init got=%b exp=00", lcout); end
        tick();
        if (cfg_done !== 1'b0) err_done++;
        total++; if (lcout !== 2'b00) begin bad++; $display("FAIL abort_reg_init got=%b exp=00", lcout); end
        in_v = 8'h1F;
        #1;
        total++; if (lcout !== 2'b10) begin bad++; $display("FAIL abort_comb_addr1 got=%b exp=10", lcout); end
        tick();
        if (cfg_done !== 1'b0) err_done++;
        total++; if (lcout !== 2'b11) begin bad++; $display("FAIL abort_reg_addr15 got=%b exp=11", lcout); end
        total++; if (err_done != 0) begin bad++; $display("FAIL abort_done_pulse got=%0d exp=0", err_done); end
    endtask

    task automatic test_restart();
        logic [31:0] bits = 32'h8000_0001;
        int err_done = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cfg_valid = 1'b1; cfg_data = 1'b0;
            tick();
            if (cfg_done !== 1'b0) err_done++;
        end
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL restart_ready got=%b exp=1", cfg_ready); end
        for (int j = 0; j < 32; j++) begin
            cfg_valid = 1'b1; cfg_data = bits[j];
            tick();
            if (j < 31 && cfg_done !== 1'b0) err_done++;
        end
        cfg_valid = 1'b0; in_v = 8'h00;
        total++; if (err_done != 0) begin bad++; $display("FAIL restart_early_done got=%0d exp=0", err_done); end
        total++; if (cfg_done !== 1'b1) begin bad++; $display("FAIL restart_done got=%b exp=1", cfg_done); end
        #1;
        total++; if (lcout !== 2'b00) begin bad++; $display("FAIL restart_first_cycle got=%b exp=00", lcout); end
        tick();
        total++; if (lcout !== 2'b01) begin bad++; $display("FAIL restart_cell0_addr0 got=%b exp=01", lcout); end
        in_v = 8'hF0;
        #1;
        total++; if (lcout !== 2'b11) begin bad++; $display("FAIL restart_cell1_addr15 got=%b exp=11", lcout); end
        in_v = 8'h0F;
        tick();
        total++; if (lcout !== 2'b00) begin bad++; $display("FAIL restart_zero_entries got=%b exp=00", lcout); end
    endtask

    initial begin
        test_reset();
        test_registered();
        test_carry();
        test_load_toggle();
        test_abort();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/logic_cell_cluster.md
LOGIC_CELL_CLUSTER -- requirements
Module: logic_cell_cluster

Interface
REQ-001 Parameter NUM_CELLS, default 8: number of logic cells in the cluster, range 1..16.
REQ-002 Parameter LUT_K, default 4: LUT inputs per cell, range 2..6; LUT depth D = 2^LUT_K.
REQ-003 Parameter LUT_INIT, default all zeros, width NUM_CELLS*D: LUT contents loaded at reset; bits [i*D +: D] belong to cell i.
REQ-004 Parameter REG_MASK, default all ones, width NUM_CELLS: bit i=1 means cell i output is registered, 0 means combinational.
REQ-005 Parameter C_ON, default all zeros, width NUM_CELLS: bit i=1 enables the carry stage of cell i.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 sr  input  1  reset, synchronous, active-high.
REQ-008 ce  input  1  clock enable for cell output registers only.
REQ-009 carryin  input  1  carry into cell 0.
REQ-010 in  input  NUM_CELLS*LUT_K  LUT inputs; cell i uses in[i*LUT_K +: LUT_K]; local input 0 is the LUT address LSB.
REQ-011 lcout  output  NUM_CELLS  cell outputs.
REQ-012 carryout  output  1  carry out of the last cell.
REQ-013 cfg_start  input  1  begin a LUT reload.
REQ-014 cfg_valid  input  1  cfg_data is valid this cycle.
REQ-015 cfg_data  input  1  serial LUT configuration bit.
REQ-016 cfg_ready  output  1  block accepts a configuration bit.
REQ-017 cfg_done  output  1  one-cycle pulse when a reload completes.

Function
REQ-018 FSM states: RUN and LOAD; there are no other states.
REQ-019 RUN + cfg_start=1 -> LOAD next cycle; bit counter cleared to 0.
REQ-020 LOAD + cfg_start=1 -> stays in LOAD; bit counter restarts at 0; bits already written stay in place.
REQ-021 In LOAD, cfg_ready=1 and cfg_start=0 gives a beat on cfg_valid=1, which writes cfg_data to LUT bit index = counter and then increments the counter.
REQ-022 Bit index j maps to cell j/D, LUT entry j mod D; bits are sent LSB first.
REQ-023 The beat at counter = NUM_CELLS*D-1 is the last: next cycle state=RUN, cfg_done=1 for exactly one cycle, counter=0.
REQ-024 In RUN, cfg_ready=0 and cfg_valid is ignored.
REQ-025 Cell LUT output = LUT_i[address formed by the cell's LUT_K inputs].
REQ-026 Carry: c_{-1}=carryin; c_i = C_ON[i] ? (a&b)|((a|b)&c_{i-1}) : 0, where a and b are local inputs 1 and 2 of cell i; carryout = c_{NUM_CELLS-1}; the path is purely combinational.
REQ-027 Registered cell (REG_MASK[i]=1) in RUN: ce=1 captures the LUT output at the clock edge; ce=0 holds. Latency is 1 cycle.
REQ-028 Combinational cell (REG_MASK[i]=0) in RUN: lcout[i] equals the LUT output in the same cycle.
REQ-029 In LOAD: lcout=0 and carryout=0; cell registers are cleared to 0 at every LOAD cycle regardless of ce.
REQ-030 First RUN cycle after LOAD: registered outputs read 0; new LUT data appears one cycle later (ce=1); combinational outputs use new LUT data immediately.
REQ-031 cfg_start and sr in the same cycle: sr wins.

Reset
REQ-032 sr=1 at a clock edge: state=RUN, counter=0, LUTs=LUT_INIT, cell registers=0, cfg_done=0, regardless of ce or any in-progress load.
REQ-033 Output values during and after reset: cfg_ready=0 and registered lcout=0; combinational lcout and carryout evaluate the LUT_INIT contents.
REQ-034 sr asserted mid-LOAD aborts the load; the partially written LUT contents are discarded.

Verification (NUM_CELLS=2, LUT_K=4, REG_MASK=2'b01, C_ON=2'b11)
REQ-035 Test: LUT_INIT cell0=16'h8000, cell1=16'hFFFE; sr, then in=8'h0F, ce=1 -> lcout[0]=1 one cycle later; lcout[1]=0 in the same cycle (in[7:4]=0).
REQ-036 Test: ce=0 while in changes from 8'h0F to 8'h00 -> lcout[0] holds 1; ce=1 -> lcout[0]=0 the next cycle.
REQ-037 Test: cfg_start, then 32 beats with cfg_data=1 and cfg_valid toggling every other cycle -> cfg_ready=1 throughout; cfg_done pulses one cycle after the 32nd accepted beat; afterwards all LUT bits =1 and lcout=2'b11 with ce=1.
REQ-038 Test: carryin=1, in[2:1]=2'b01, in[6:5]=2'b01 in RUN -> carryout=1; with carryin=0 -> carryout=0.
REQ-039 Test: sr at beat 10 of a load -> LUTs read back LUT_INIT behaviour; cfg_done never pulses; cfg_ready=0.
REQ-040 Test: cfg_start re-asserted at beat 5 -> 32 further beats are required before cfg_done pulses.
